// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit
//
// Purpose: computes MULT, MULTU, DIV and DIVU one bit per cycle. The result
// lands in the architectural HI/LO registers 33 cycles after the accepting
// edge. HI and LO can also be written directly while the unit is idle.
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   reset        asynchronous active-low reset
//   start        launch an operation (sampled only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands, captured on the accepting edge
//   mthi, mtlo   direct-write strobes for HI / LO (IDLE, start low)
//   wdata        data for mthi / mtlo
//   busy         operation in flight (MUL, DIV, FIN)
//   done         one-cycle pulse while in FIN (HI/LO just updated)
//   divzero      last completed divide had b == 0; held until next done
//   hi, lo       architectural HI and LO
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  // Shared working register.
  //   MUL: upper half = partial product, lower half = multiplier (shifted out)
  //   DIV: upper half = partial remainder, lower half = dividend -> quotient
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   a_q;      // original dividend, returned as HI on b == 0
  logic               neg_q;    // negate product / quotient
  logic               rneg_q;   // negate remainder (dividend was negative)
  logic               bzero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_q;

  // Operand magnitudes at the accepting edge; op[0] = 0 selects signed forms.
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the whole accumulator right, keeping the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: the shifted remainder is below 2*divisor, so the signed
  // difference fits in WIDTH+1 bits and its top bit is the borrow.
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign correction applied on the commit cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q  ? -acc : acc;
  assign quo_fix  = neg_q  ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= op[1] ? S_DIV : S_MUL;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            opnd    <= op[1] ? b_mag : a_mag;
            a_q     <= a;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            bzero_q <= (b == '0);
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        // Cycles 1..WIDTH iterate; the following cycle commits to HI/LO.
        S_MUL: begin
          if (cnt == CW'(WIDTH)) begin
            hi_q  <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q  <= prod_fix[WIDTH-1:0];
            dz_q  <= 1'b0;
            state <= S_FIN;
          end else begin
            acc <= mul_next;
            cnt <= cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (cnt == CW'(WIDTH)) begin
            if (bzero_q) begin
              hi_q <= a_q;
              lo_q <= '1;
              dz_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
              dz_q <= 1'b0;
            end
            state <= S_FIN;
          end else begin
            acc <= div_next;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_FIN);
  assign divzero = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
